// File: rtl/grad_accum_outer.sv
// grad_accum_outer
//    Backward-pass gradient accumulator. One run streams a full weight tile
//    of slot `slot` through the gradient RAMs:
//       grad_w[slot] += d_forward^T * d_backward   (DATA_N lanes per beat)
//       grad_b[slot] += d_backward
//    In clear mode the products / d_backward overwrite the stored values.
//    The pipeline is read -> product register -> write, which gives a fixed
//    2-cycle read-to-write latency. Every address is touched once per pass,
//    so no hazard forwarding is needed.
//
// Ports
//    clk, rst_n          clock, asynchronous active-low reset
//    run                 level start/hold; low aborts and returns to idle
//    slot, clear         layer slot and overwrite mode, sampled at start
//    d_forward           IN_DIM  x N_LEN signed operands, element i at [i*N_LEN +: N_LEN]
//    d_backward          OUT_DIM x N_LEN signed operands, same packing
//    valid               pass complete (held until run falls)
//    err                 one-cycle pulse on an illegal slot
//    raddr_w/waddr_w     weight RAM addresses; rdata_w (1-cycle latency),
//    wdata_w, we_w       weight RAM write data / enable
//    raddr_b/waddr_b     bias RAM addresses; rdata_b (1-cycle latency),
//    wdata_b, we_b       bias RAM write data / enable
//
// Build option
//    GRAD_SAT_EN         when defined, accumulates saturate to the signed
//                        N_LEN_W range instead of wrapping.

module grad_accum_outer #(
   parameter int  IN_DIM     = 24,
   parameter int  OUT_DIM    = 24,
   parameter int  DATA_N     = 8,
   parameter int  N_LEN      = 16,
   parameter int  F_LEN      = 8,
   parameter int  N_LEN_W    = 24,
   parameter int  N_SLOT     = 3,
   parameter int  ADDR_WIDTH = 9,
   localparam int SLOT_W     = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        run,
   input  logic [SLOT_W-1:0]           slot,
   input  logic                        clear,
   input  logic [IN_DIM*N_LEN-1:0]     d_forward,
   input  logic [OUT_DIM*N_LEN-1:0]    d_backward,
   output logic                        valid,
   output logic                        err,
   output logic [ADDR_WIDTH-1:0]       raddr_w,
   output logic [ADDR_WIDTH-1:0]       waddr_w,
   input  logic [DATA_N*N_LEN_W-1:0]   rdata_w,
   output logic [DATA_N*N_LEN_W-1:0]   wdata_w,
   output logic                        we_w,
   output logic [ADDR_WIDTH-1:0]       raddr_b,
   output logic [ADDR_WIDTH-1:0]       waddr_b,
   input  logic [N_LEN_W-1:0]          rdata_b,
   output logic [N_LEN_W-1:0]          wdata_b,
   output logic                        we_b
);

   localparam int W_BEATS = IN_DIM * OUT_DIM / DATA_N;
   localparam int N_CG    = OUT_DIM / DATA_N;
   localparam int ROW_W   = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
   localparam int CG_W    = (N_CG    > 1) ? $clog2(N_CG)    : 1;
   localparam int BK_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int PROD_W  = 2 * N_LEN;
   localparam int EXT_W   = PROD_W + N_LEN_W;

   localparam logic [ADDR_WIDTH-1:0] W_STEP  = ADDR_WIDTH'(W_BEATS);
   localparam logic [ADDR_WIDTH-1:0] B_STEP  = ADDR_WIDTH'(OUT_DIM);
   localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IN_DIM - 1);
   localparam logic [CG_W-1:0]       CG_LAST  = CG_W'(N_CG - 1);
   localparam logic [BK_W-1:0]       BK_LAST  = BK_W'(OUT_DIM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t state_q, state_d;
   logic   err_d;

   // Read-issue stage: beat k is decomposed into row / column-group counters
   // so no divider is needed to pick the operands.
   logic                  rd_act, rd_b_act;
   logic [ROW_W-1:0]      rd_row;
   logic [CG_W-1:0]       rd_col;
   logic [BK_W-1:0]       rd_bk;

   // Product stage.
   logic                  s1_act, s1_b_act, s1_last;
   logic [N_LEN_W-1:0]    s1_prod [DATA_N];
   logic [N_LEN_W-1:0]    s1_bias;
   logic [ADDR_WIDTH-1:0] s1_addr_w, s1_addr_b;
   logic                  clear_q;

   logic                  slot_ok;
   logic [ADDR_WIDTH-1:0] wb_in, bb_in;
   logic                  last_beat;

   logic signed [N_LEN-1:0] fwd     [IN_DIM];
   logic signed [N_LEN-1:0] bwd     [OUT_DIM];
   logic signed [N_LEN-1:0] bwd_grp [N_CG][DATA_N];
   logic [N_LEN_W-1:0]      prod_d  [DATA_N];
   logic [N_LEN_W-1:0]      bias_d;

   // Fixed-point product: full signed product, sign-extended, arithmetic
   // shift by F_LEN (floor toward -inf), keep N_LEN_W bits.
   function automatic logic [N_LEN_W-1:0] scale_prod(
      input logic signed [N_LEN-1:0] a,
      input logic signed [N_LEN-1:0] b
   );
      logic signed [PROD_W-1:0] p;
      logic signed [EXT_W-1:0]  pe;
      p  = a * b;
      pe = EXT_W'(p);
      pe = pe >>> F_LEN;
      return pe[N_LEN_W-1:0];
   endfunction

`ifdef GRAD_SAT_EN
   localparam logic [N_LEN_W-1:0] ACC_MAX = {1'b0, {(N_LEN_W-1){1'b1}}};
   localparam logic [N_LEN_W-1:0] ACC_MIN = {1'b1, {(N_LEN_W-1){1'b0}}};
`endif

   function automatic logic [N_LEN_W-1:0] acc_add(
      input logic [N_LEN_W-1:0] a,
      input logic [N_LEN_W-1:0] b
   );
      logic [N_LEN_W-1:0] s;
      s = a + b;
`ifdef GRAD_SAT_EN
      // Overflow only when both operands share a sign the sum does not.
      if ((a[N_LEN_W-1] == b[N_LEN_W-1]) && (s[N_LEN_W-1] != a[N_LEN_W-1]))
         s = a[N_LEN_W-1] ? ACC_MIN : ACC_MAX;
`endif
      return s;
   endfunction

   assign slot_ok   = ({1'b0, slot} < (SLOT_W+1)'(N_SLOT));
   assign wb_in     = ADDR_WIDTH'(slot) * W_STEP;
   assign bb_in     = ADDR_WIDTH'(slot) * B_STEP;
   assign last_beat = (rd_row == ROW_LAST) && (rd_col == CG_LAST);

   always_comb begin
      for (int unsigned i = 0; i < IN_DIM; i++)
         fwd[i] = d_forward[i*N_LEN +: N_LEN];
      for (int unsigned i = 0; i < OUT_DIM; i++)
         bwd[i] = d_backward[i*N_LEN +: N_LEN];
      for (int unsigned g = 0; g < N_CG; g++)
         for (int unsigned j = 0; j < DATA_N; j++)
            bwd_grp[g][j] = d_backward[(g*DATA_N + j)*N_LEN +: N_LEN];
   end

   always_comb begin
      for (int unsigned j = 0; j < DATA_N; j++)
         prod_d[j] = scale_prod(fwd[rd_row], bwd_grp[rd_col][j]);
      bias_d = N_LEN_W'(bwd[rd_bk]);
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               if (slot_ok) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (!run)
               state_d = S_IDLE;
            else if (s1_act && s1_last)
               state_d = S_DONE;
         end
         S_DONE, S_ERR: begin
            if (!run)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         valid   <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         valid   <= (state_d == S_DONE);
         err     <= err_d;
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_act    <= 1'b0;
         rd_b_act  <= 1'b0;
         rd_row    <= '0;
         rd_col    <= '0;
         rd_bk     <= '0;
         s1_act    <= 1'b0;
         s1_b_act  <= 1'b0;
         s1_last   <= 1'b0;
         for (int unsigned j = 0; j < DATA_N; j++)
            s1_prod[j] <= '0;
         s1_bias   <= '0;
         s1_addr_w <= '0;
         s1_addr_b <= '0;
         clear_q   <= 1'b0;
         raddr_w   <= '0;
         waddr_w   <= '0;
         raddr_b   <= '0;
         waddr_b   <= '0;
         wdata_w   <= '0;
         wdata_b   <= '0;
         we_w      <= 1'b0;
         we_b      <= 1'b0;
      end else if (state_q == S_IDLE) begin
         // Idle: addresses follow the slot input, so at the start edge the
         // read address already equals the slot base (beat 0).
         raddr_w  <= wb_in;
         raddr_b  <= bb_in;
         waddr_w  <= wb_in;
         waddr_b  <= bb_in;
         we_w     <= 1'b0;
         we_b     <= 1'b0;
         s1_act   <= 1'b0;
         s1_b_act <= 1'b0;
         rd_row   <= '0;
         rd_col   <= '0;
         rd_bk    <= '0;
         rd_act   <= run && slot_ok;
         rd_b_act <= run && slot_ok;
         clear_q  <= clear;
      end else if (!run) begin
         rd_act   <= 1'b0;
         rd_b_act <= 1'b0;
         s1_act   <= 1'b0;
         s1_b_act <= 1'b0;
         we_w     <= 1'b0;
         we_b     <= 1'b0;
      end else begin
         // Stage 0 -> 1: capture products for the beat whose read is in flight.
         s1_act   <= rd_act;
         s1_b_act <= rd_b_act;
         s1_last  <= rd_act && last_beat;
         if (rd_act) begin
            s1_addr_w <= raddr_w;
            for (int unsigned j = 0; j < DATA_N; j++)
               s1_prod[j] <= prod_d[j];
            if (last_beat) begin
               rd_act <= 1'b0;
            end else begin
               raddr_w <= raddr_w + ADDR_WIDTH'(1);
               if (rd_col == CG_LAST) begin
                  rd_col <= '0;
                  rd_row <= rd_row + ROW_W'(1);
               end else begin
                  rd_col <= rd_col + CG_W'(1);
               end
            end
         end
         if (rd_b_act) begin
            s1_addr_b <= raddr_b;
            s1_bias   <= bias_d;
            if (rd_bk == BK_LAST) begin
               rd_b_act <= 1'b0;
            end else begin
               rd_bk   <= rd_bk + BK_W'(1);
               raddr_b <= raddr_b + ADDR_WIDTH'(1);
            end
         end

         // Stage 1 -> 2: rdata for the same beat arrives now; accumulate.
         we_w <= s1_act;
         we_b <= s1_b_act;
         if (s1_act) begin
            waddr_w <= s1_addr_w;
            for (int unsigned j = 0; j < DATA_N; j++)
               wdata_w[j*N_LEN_W +: N_LEN_W] <= clear_q ? s1_prod[j]
                  : acc_add(rdata_w[j*N_LEN_W +: N_LEN_W], s1_prod[j]);
         end
         if (s1_b_act) begin
            waddr_b <= s1_addr_b;
            wdata_b <= clear_q ? s1_bias : acc_add(rdata_b, s1_bias);
         end
      end
   end

endmodule

// File: doc/grad_accum_outer.md
# grad_accum_outer

Parametrised backward-pass gradient accumulator for fully connected and mix layers. Each run streams one weight-gradient tile pass through a synchronous gradient RAM, computing `grad_w[slot] += d_forward^T · d_backward` with DATA_N lanes per beat. In parallel it computes `grad_b[slot] += d_backward`. It sits between the backward datapath and the gradient RAMs and is started by the training controller. It supports arbitrary IN_DIM/OUT_DIM, N_SLOT layer slots, an overwrite (clear) mode and optional saturation.

## Interface
- IN_DIM, 24: d_forward length (weight rows).
- OUT_DIM, 24: d_backward length (weight cols, bias entries); multiple of DATA_N.
- DATA_N, 8: lanes per weight-RAM word.
- N_LEN, 16: operand width, signed fixed point.
- F_LEN, 8: fraction bits.
- N_LEN_W, 24: gradient word width (≥ N_LEN).
- N_SLOT, 3: layer slots in the shared gradient RAMs.
- ADDR_WIDTH, 9: RAM address width; ≥ clog2(N_SLOT·IN_DIM·OUT_DIM/DATA_N).
- Constraint: IN_DIM ≥ DATA_N, so that OUT_DIM ≤ W_BEATS = IN_DIM·OUT_DIM/DATA_N.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset.
- run, in, 1: level start/hold; low aborts and returns to IDLE.
- slot, in, clog2(N_SLOT): layer slot; sampled at IDLE→RUN.
- clear, in, 1: overwrite mode; sampled at IDLE→RUN.
- d_forward, in, IN_DIM·N_LEN: element i at [i·N_LEN +: N_LEN]; held stable while run is high.
- d_backward, in, OUT_DIM·N_LEN: same packing; held stable while run is high.
- valid, out, 1: pass complete.
- err, out, 1: one-cycle pulse on an illegal slot.
- raddr_w / waddr_w, out, ADDR_WIDTH: weight RAM read and write addresses.
- rdata_w, in, DATA_N·N_LEN_W: weight RAM read data; 1-cycle read latency.
- wdata_w, out, DATA_N·N_LEN_W: weight RAM write data.
- we_w, out, 1: weight RAM write enable.
- raddr_b / waddr_b, out, ADDR_WIDTH: bias RAM read and write addresses.
- rdata_b, in, N_LEN_W: bias RAM read data; 1-cycle read latency.
- wdata_b, out, N_LEN_W: bias RAM write data.
- we_b, out, 1: bias RAM write enable.

Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
State machine:
- IDLE → RUN when run=1 and slot < N_SLOT.
- IDLE → ERR when run=1 and slot ≥ N_SLOT. ERR pulses err for one cycle, then waits in ERR until run=0, then returns to IDLE.
- RUN → DONE after the last write issues.
- DONE holds until run=0, then returns to IDLE.
- Any state goes to IDLE when run=0.

Base addresses:
- Weight base WB = slot·W_BEATS.
- Bias base BB = slot·OUT_DIM.

Weight beat k (0..W_BEATS−1):
- Row r = k / (OUT_DIM/DATA_N); column group c = k mod (OUT_DIM/DATA_N).
- For each lane j: prod_j = d_forward[r] · d_backward[c·DATA_N+j].
- prod_j is a 2·N_LEN signed product. Take bits [F_LEN +: N_LEN_W] after sign extension; this is an arithmetic shift, truncating toward −∞.
- wdata lane j = rdata lane j + prod_j. In clear mode, wdata lane j = prod_j and rdata is ignored.

Bias beat k (0..OUT_DIM−1):
- wdata_b = rdata_b + sign-extended d_backward[k].
- In clear mode, wdata_b = sign-extended d_backward[k].

Addition width: N_LEN_W bits, two's-complement wrap (but see Configuration).

Abort: if run drops mid-pass, we_w and we_b deassert on the next edge and no further writes occur. Counters reset, and a partially updated slot is left as is.

Each address is written exactly once per pass.

## Timing
Edge E0 is the first edge sampling run=1 in IDLE.
- After edge Ek: raddr_w = WB+k, and raddr_b = BB+k for k < OUT_DIM.
- After edge Ek+1: rdata is captured and the product register is loaded.
- After edge Ek+2: we_w=1, waddr_w = WB+k, and wdata_w is valid.
- Read-to-write latency is 2 cycles.

Bias writes use the same pipeline; we_b is high only for k < OUT_DIM.

Completion:
- valid rises after E(W_BEATS+1), i.e. in the same cycle as the last weight write.
- valid holds in DONE and drops one cycle after run falls.

Same-address hazards: none, since every address is touched once per pass.

Outputs while idle:
- raddr_w = WB of the current slot input; raddr_b = BB.
- waddr outputs mirror these.
- All enables are 0.

Reset values:
- All addresses, wdata, we_w, we_b, valid and err are 0.
- State is IDLE.

## Configuration
GRAD_SAT_EN:
- Defined: every accumulate (weight lanes and bias) saturates to [−2^(N_LEN_W−1), 2^(N_LEN_W−1)−1].
- Undefined: accumulates wrap modulo 2^N_LEN_W.
- The product path is unaffected in both cases.

## Test plan
Test parameters: IN_DIM=4, OUT_DIM=4, DATA_N=2, N_LEN=16, F_LEN=8, N_LEN_W=24, N_SLOT=3.

1. Basic accumulate: d_forward all 256 (1.0), d_backward all 512 (2.0), RAM contents 0, slot=1 → 8 weight writes to addresses 8..15, each lane 512. Bias writes to addresses 4..7 = 512. valid first high in the cycle of the write to address 15.
2. Accumulate vs clear: RAM preset to 100.
   - clear=0 → weight lanes = 612 and bias = 612.
   - clear=1 → weight lanes = 512 and bias = 512.
3. Product truncation: d_forward[0] = −1 (0xFFFF), d_backward[0] = 1 → weight lane = 0xFFFFFF (−1 LSB); this is the arithmetic-shift check.
4. Saturation: rdata lane = 0x7FFFFF, product = +512.
   - With GRAD_SAT_EN → 0x7FFFFF.
   - Without it → 0x8001FF.
5. Abort: run dropped after E3 → at most addresses WB+0..WB+1 are written, no we_w/we_b afterwards, valid never rises. A following run completes normally.
6. Illegal slot: slot=3 → err pulses for one cycle, no writes occur, valid stays 0. rst_n asserted mid-pass → all outputs 0 asynchronously.
